// File: rtl/fpu_pkg.sv
// Shared FPU types: operation encoding, issuer FSM states and the command payload.
package fpu_pkg;

    typedef enum logic [1:0] {
        FPU_ADD = 2'd0,
        FPU_SUB = 2'd1,
        FPU_MUL = 2'd2,
        FPU_DIV = 2'd3
    } fpu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } issuer_state_t;

    localparam int unsigned FPU_PREC = 32;

    typedef struct packed {
        logic [FPU_PREC-1:0] a;
        logic [FPU_PREC-1:0] b;
        fpu_op_t             op;
    } fpu_cmd_t;

endpackage

// File: rtl/fpu_cmd_issuer_fifo.sv
// Parameterised synchronous FIFO holding packed FPU commands; pointers carry one wrap bit.
module fpu_cmd_fifo #(
    parameter int unsigned WIDTH = 66,
    parameter int unsigned DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push && !Reset) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Issues buffered commands to the FPU one at a time (load strobe, settle, wait for Done) and returns results.
// `FPU_CMD_ISSUER_TIMEOUT_EN adds a Done watchdog: after TIMEOUT WAIT cycles it responds with rsp_err=1.
module fpu_cmd_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned PRECISION = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [PRECISION-1:0] cmd_a,
    input  logic [PRECISION-1:0] cmd_b,
    input  logic [1:0]           cmd_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PRECISION-1:0] rsp_result,
    output logic [1:0]           rsp_op,
    output logic                 rsp_err,
    output logic [PRECISION-1:0] fpu_a,
    output logic [PRECISION-1:0] fpu_b,
    output logic [1:0]           fpu_op,
    output logic                 fpu_load,
    input  logic [PRECISION-1:0] fpu_result,
    input  logic                 fpu_done
);
    localparam int unsigned CMD_W = 2*PRECISION + 2;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_cfg
        $error("fpu_cmd_issuer: DEPTH must be a power of two >= 2 and TIMEOUT nonzero");
    end

    issuer_state_t        state_q;
    logic [PRECISION-1:0] fpu_a_q, fpu_b_q, rsp_result_q;
    fpu_op_t              fpu_op_q, rsp_op_q;
    logic                 fpu_load_q, rsp_valid_q;
    logic [CMD_W-1:0]     head;
    logic                 fifo_full, fifo_empty, pop;

    assign pop       = (state_q == ST_IDLE) && !fifo_empty && !rsp_valid_q;
    assign cmd_ready = !fifo_full || pop;

    fpu_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_a, cmd_b, cmd_op}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Operands stay in fpu_*_q from the pop until the next pop, so the divider sees stable inputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= FPU_ADD;
            fpu_load_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= FPU_ADD;
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
            wait_cnt_q   <= '0;
`endif
        end else begin
            fpu_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (pop) begin
                    fpu_a_q    <= head[CMD_W-1 -: PRECISION];
                    fpu_b_q    <= head[PRECISION+1 -: PRECISION];
                    fpu_op_q   <= fpu_op_t'(head[1:0]);
                    fpu_load_q <= 1'b1;
                    state_q    <= ST_LOAD;
                end
                ST_LOAD: state_q <= ST_SETTLE;
                ST_SETTLE: begin
                    state_q <= ST_WAIT;
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    if (fpu_done) begin
                        rsp_result_q <= fpu_result;
                        rsp_op_q     <= fpu_op_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
                        rsp_err_q    <= 1'b0;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        rsp_result_q <= '0;
                        rsp_op_q     <= fpu_op_q;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`endif
                    end
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_op     = fpu_op_q;
    assign fpu_load   = fpu_load_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_op     = rsp_op_q;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Bench for fpu_cmd_issuer: FPU stub with per-op latency, in-order response scoreboard, directed and random steps.
module tb_fpu_cmd_issuer;
    import fpu_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic [1:0]  op;
        logic        err;
    } rsp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0;
    logic [1:0]  cmd_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_op;
    logic        rsp_err;
    logic [31:0] fpu_a, fpu_b;
    logic [1:0]  fpu_op;
    logic        fpu_load;
    logic [31:0] fpu_result = '0;
    logic        fpu_done = 1'b0;

    int   checks = 0;
    int   failures = 0;
    int   load_cnt = 0;
    int   stub_cnt = 0;
    int   stub_extra = 0;
    logic stub_mute = 1'b0;

    rsp_t     exp_q[$];
    fpu_cmd_t cmd_q[$];

    always #5 Clk = ~Clk;

    fpu_cmd_issuer #(.PRECISION(32), .DEPTH(4), .TIMEOUT(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_load(fpu_load),
        .fpu_result(fpu_result), .fpu_done(fpu_done)
    );

    // Known IEEE-754 results for the directed cases; anything else gets a deterministic hash.
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (op == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 2'd1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        if (op == 2'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (op == 2'd3 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, op} + 32'h9E3779B9;
    endfunction

    function automatic int fpu_lat(input logic [1:0] op);
        case (op)
            2'd0:    return 2;
            2'd1:    return 3;
            2'd2:    return 1;
            default: return 6;
        endcase
    endfunction

    // FPU stub: load strobe starts an operation, Done pulses once N cycles after the settle cycle.
    always @(posedge Clk) begin
        if (Reset) begin
            stub_cnt <= 0;
            fpu_done <= 1'b0;
        end else if (fpu_load) begin
            stub_cnt   <= fpu_lat(fpu_op) + stub_extra;
            fpu_done   <= 1'b0;
            fpu_result <= fpu_model(fpu_a, fpu_b, fpu_op);
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            fpu_done <= (stub_cnt == 1) && !stub_mute;
        end else begin
            fpu_done <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One clock: score handshakes on settled pre-edge values, then advance to 1 time unit past the edge.
    task automatic tick();
        rsp_t     e;
        fpu_cmd_t c;
        if (!Reset && fpu_done && cmd_q.size() != 0) begin
            c = cmd_q[0];
            chk("hold_a", fpu_a, c.a);
            chk("hold_b", fpu_b, c.b);
            chk("hold_op", 32'(fpu_op), 32'(c.op));
        end
        if (!Reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                c = cmd_q.pop_front();
                chk("rsp_result", rsp_result, e.result);
                chk("rsp_op", 32'(rsp_op), 32'(e.op));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
        if (!Reset && cmd_valid && cmd_ready) begin
            c.a  = cmd_a;
            c.b  = cmd_b;
            c.op = fpu_op_t'(cmd_op);
            cmd_q.push_back(c);
            e.result = stub_mute ? 32'd0 : fpu_model(cmd_a, cmd_b, cmd_op);
            e.op     = cmd_op;
            e.err    = stub_mute;
            exp_q.push_back(e);
        end
        @(posedge Clk);
        #1;
        if (fpu_load) load_cnt++;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        chk("send_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 1000) begin tick(); n++; end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_result"}, rsp_result, 32'd0);
        chk({tag, "_rsp_op"}, 32'(rsp_op), 32'd0);
        chk({tag, "_fpu_a"}, fpu_a, 32'd0);
        chk({tag, "_fpu_b"}, fpu_b, 32'd0);
        chk({tag, "_fpu_op"}, 32'(fpu_op), 32'd0);
        chk({tag, "_fpu_load"}, 32'(fpu_load), 32'd0);
    endtask

    initial begin
        int n;

        // Power-on reset.
        Reset = 1'b1;
        repeat (2) tick();
        chk_reset_values("por");
        Reset = 1'b0;
        tick();

        // Add: single load pulse and the exact sum.
        rsp_ready = 1'b1;
        load_cnt  = 0;
        send(32'h3F800000, 32'h40000000, 2'd0);
        drain();
        chk("add_load_cycles", 32'(load_cnt), 32'd1);

        // Mul: rsp_valid four cycles after the push.
        cmd_a = 32'h40000000; cmd_b = 32'h40400000; cmd_op = 2'd2; cmd_valid = 1'b1;
        chk("mul_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        chk("mul_latency", 32'(n), 32'd4);
        chk("mul_result", rsp_result, 32'h40C00000);
        drain();

        // Burst of five under backpressure fills the FIFO.
        rsp_ready = 1'b0;
        send(32'h40C00000, 32'h40000000, 2'd3);
        send(32'h40400000, 32'h3F800000, 2'd1);
        for (int i = 0; i < 3; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)));
        chk("burst_full_ready", 32'(cmd_ready), 32'd0);
        cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'd0; cmd_valid = 1'b1;
        repeat (3) begin
            chk("burst_push_ignored", 32'(cmd_ready), 32'd0);
            tick();
        end
        chk("burst_queued", 32'(exp_q.size()), 32'd5);

        // Releasing the response lets the IDLE pop and a push coincide while full.
        rsp_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 40) begin tick(); n++; end
        chk("pushpop_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("pushpop_popped", 32'(fpu_load), 32'd1);
        chk("pushpop_still_full", 32'(cmd_ready), 32'd0);
        chk("pushpop_queued", 32'(exp_q.size()), 32'd5);
        drain();

        // Random traffic with random FPU latency and consumer stalls.
        for (int i = 0; i < 80; i++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_a      = $urandom;
            cmd_b      = $urandom;
            cmd_op     = 2'($urandom_range(0, 3));
            rsp_ready  = 1'($urandom_range(0, 1));
            stub_extra = $urandom_range(0, 3);
            tick();
        end
        drain();
        stub_extra = 0;

        // Reset while a div sits in WAIT with more commands queued.
        send(32'h40C00000, 32'h40000000, 2'd3);
        cmd_a = 32'h3F800000; cmd_b = 32'h40000000; cmd_op = 2'd0; cmd_valid = 1'b1;
        n = 0;
        while (!fpu_load && n < 10) begin tick(); n++; end
        chk("rst_div_loaded", 32'(fpu_load), 32'd1);
        repeat (2) tick();
        cmd_valid = 1'b0;
        chk("rst_queued", 32'(exp_q.size()), 32'd4);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_q.delete();
        cmd_q.delete();
        chk_reset_values("rst");
        load_cnt = 0;
        repeat (6) tick();
        chk("rst_fifo_flushed", 32'(load_cnt), 32'd0);
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        send(32'h3F800000, 32'h40000000, 2'd0);
        drain();
        chk("rst_fresh_add_loads", 32'(load_cnt), 32'd1);

`ifdef FPU_CMD_ISSUER_TIMEOUT_EN
        // Done never arrives: error response after eight WAIT cycles.
        stub_mute = 1'b1;
        cmd_a = 32'h3F800000; cmd_b = 32'h40000000; cmd_op = 2'd0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        chk("timeout_latency", 32'(n), 32'd11);
        chk("timeout_err", 32'(rsp_err), 32'd1);
        chk("timeout_result", rsp_result, 32'd0);
        drain();
        stub_mute = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_cmd_issuer.md
# fpu_cmd_issuer

Initiator side of the FPU operand/load/Done protocol. Accepts floating-point commands over a valid/ready stream, buffers them in a small FIFO, drives the FPU's operand, operation and load inputs one transaction at a time, waits for Done, and returns results over a second valid/ready stream. It sits between a host or sequencer and the `FPU` instance, so no client ever toggles the FPU's load pin directly.

## Interface
- `PRECISION`, 32, operand/result width in bits (IEEE-754 single).
- `DEPTH`, 4, command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 255, max wait cycles for `fpu_done` (used only with the timeout feature).
- `Clk` in 1: clock; all state updates on posedge.
- `Reset` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: FIFO not full.
- `cmd_a` in PRECISION: operand A.
- `cmd_b` in PRECISION: operand B.
- `cmd_op` in 2: 00 add, 01 sub, 10 mul, 11 div.
- `rsp_valid` out 1: result held.
- `rsp_ready` in 1: consumer accepts.
- `rsp_result` out PRECISION: FPU result.
- `rsp_op` out 2: op that produced it.
- `rsp_err` out 1: timeout flag; constant 0 without the timeout feature.
- `fpu_a`, `fpu_b` out PRECISION: drive FPU `A`, `B`.
- `fpu_op` out 2: drives FPU `Operation`.
- `fpu_load` out 1: drives FPU `Reset` (load strobe).
- `fpu_result` in PRECISION: FPU `Result`.
- `fpu_done` in 1: FPU `Done`.

## Operation
- Command push on `cmd_valid & cmd_ready`. Pop only in IDLE when the FIFO is not empty and there is no pending response.
- States are IDLE → LOAD → SETTLE → WAIT → RESP → IDLE.
- IDLE: if the FIFO is not empty, pop the head into the `fpu_a`/`fpu_b`/`fpu_op` registers and go to LOAD.
- LOAD: `fpu_load`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one cycle; `fpu_done` is ignored because the FPU masks Done for one cycle after load. Go to WAIT.
- WAIT: on `fpu_done`=1, capture `fpu_result` and op into the response registers, set `rsp_valid`, and go to RESP.
- RESP: hold `rsp_*` until `rsp_ready`, then clear `rsp_valid` and go to IDLE.
- `fpu_a`, `fpu_b` and `fpu_op` stay stable from LOAD until the exit from WAIT, because the divider reads stored operands throughout.
- FIFO full: `cmd_ready`=0 and pushes are ignored.
- FIFO empty: remain in IDLE.
- Push and pop in the same cycle: occupancy is unchanged. This is legal even when the FIFO is full, because the pop frees a slot first, so `cmd_ready` is computed as `!full | pop`.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs equal.
- Reset (any state, including mid-transaction): the FSM goes to IDLE and the FIFO is flushed.
- Values after reset: `fpu_load`=0, `rsp_valid`=0, `rsp_err`=0, `cmd_ready`=1, `rsp_result`=0, `rsp_op`=0, `fpu_a`=`fpu_b`=0, `fpu_op`=0.
- The in-flight FPU operation is abandoned; the next LOAD re-initialises the FPU.

## Timing
- Latency from push into an empty FIFO to `rsp_valid` is 1 (IDLE pop) + 1 (LOAD) + 1 (SETTLE) + N, where N is the number of cycles until `fpu_done`.
- For mul, N=1, so `rsp_valid` rises in cycle 4 after the push.
- Back-to-back throughput is one command per (4 + N + response-stall) cycles. There is no overlap, because the FPU is single-issue.
- `fpu_load` is registered and glitch-free. It rises on a posedge, and the FPU samples it on the following negedge.
- `rsp_*` are registered; `cmd_ready` is combinational from the FIFO count and the pop.

## Configuration
- Macro: `FPU_CMD_ISSUER_TIMEOUT_EN`.
- Defined: an 8–16 bit counter clears on entry to WAIT and increments each WAIT cycle. When it reaches `TIMEOUT` without `fpu_done`, the block goes to RESP with `rsp_result`=0 and `rsp_err`=1.
- Not defined: there is no counter, WAIT blocks indefinitely, and `rsp_err` is tied to 0.

## Structure
- Shared package `fpu_pkg`:
  - `fpu_op_t` enum: `FPU_ADD`=0, `FPU_SUB`=1, `FPU_MUL`=2, `FPU_DIV`=3.
  - `issuer_state_t`.
  - Command struct {a, b, op}.
- Sub-module `fpu_cmd_fifo` (parameterised sync FIFO, width 2·PRECISION+2), instantiated once; the FSM and response registers live in the top.

## Test plan
- Add: push 0x3F800000 + 0x40000000, op 00 → `fpu_load` pulses exactly 1 cycle; `rsp_result`=0x40400000, `rsp_op`=00, `rsp_err`=0.
- Mul timing: push 0x40000000 × 0x40400000, op 10 → `rsp_result`=0x40C00000, `rsp_valid` exactly 4 cycles after the push.
- Burst with backpressure: push 5 commands (DEPTH=4) while the first executes and `rsp_ready`=0 → `cmd_ready` drops when the FIFO is full. Responses must come out in order (div 0x40C00000/0x40000000 → 0x40400000; sub 0x40400000−0x3F800000 → 0x40000000), with no loss.
- Simultaneous push/pop while full → occupancy stays 4, and the pushed command is delivered later.
- Reset asserted in WAIT of a div → next cycle IDLE, FIFO empty, `rsp_valid`=0. A fresh add afterwards completes correctly.
- With `FPU_CMD_ISSUER_TIMEOUT_EN` and `TIMEOUT`=8, hold `fpu_done`=0 → after 8 WAIT cycles, `rsp_err`=1 and `rsp_result`=0.
